// File: rtl/mealy_seq_detector.sv
// Serial pattern detector with a same-cycle Mealy match, a registered copy and
// a saturating match counter. The pattern is reloadable at run time.
module mealy_seq_detector #(
  parameter int unsigned        PAT_W    = 4,
  parameter logic [PAT_W-1:0]   PAT_INIT = PAT_W'(4'b1011),
  parameter bit                 OVERLAP  = 1'b1,
  parameter int unsigned        CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     x,
  input  logic                     pat_load,
  input  logic [PAT_W-1:0]         pat_in,
  output logic                     match,
  output logic                     match_q,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [$clog2(PAT_W)-1:0] fill
);

  localparam int unsigned     FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]   FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q,  pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             mq_q,   mq_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [PAT_W-1:0] window;

  // Newest bit enters at the LSB, so the oldest history bit lines up with pat MSB.
  assign window = {hist_q, x};
  assign match  = in_valid & ~pat_load & ~reset &
                  (fill_q == FILL_MAX) & (window == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    mq_d   = 1'b0;
    cnt_d  = cnt_q;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      if (match && !OVERLAP) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[PAT_W-2:0];
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
      end
      mq_d = match;
      if (match && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= PAT_INIT;
      hist_q <= '0;
      fill_q <= '0;
      mq_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      mq_q   <= mq_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_q   = mq_q;
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Bench for mealy_seq_detector: three instances (overlap, non-overlap, 2-bit
// counter) share stimulus and are checked against a bit-queue reference model.
module tb_mealy_seq_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b0, in_valid = 1'b0, x = 1'b0, pat_load = 1'b0;
  logic [3:0] pat_in = '0;

  logic       m_a, mq_a_o, m_b, mq_b_o, m_c, mq_c_o;
  logic [7:0] cnt_a_o, cnt_b_o;
  logic [1:0] cnt_c_o;
  logic [1:0] fill_a, fill_b, fill_c;

  mealy_seq_detector #(.PAT_W(4), .PAT_INIT(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .match(m_a), .match_q(mq_a_o), .match_cnt(cnt_a_o), .fill(fill_a));
  mealy_seq_detector #(.PAT_W(4), .PAT_INIT(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .match(m_b), .match_q(mq_b_o), .match_cnt(cnt_b_o), .fill(fill_b));
  mealy_seq_detector #(.PAT_W(4), .PAT_INIT(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .match(m_c), .match_q(mq_c_o), .match_cnt(cnt_c_o), .fill(fill_c));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: last valid bits (oldest first, at most 3 kept) since last clear.
  bit         qa[$];
  bit         qb[$];
  logic [3:0] pat_m = 4'b1011;
  int         cnt_a = 0, cnt_b = 0, cnt_c = 0;
  bit         mq_a = 1'b0, mq_b = 1'b0, mq_c = 1'b0;

  typedef struct {
    bit         r, v, xb, l;
    logic [3:0] p;
    bit         em;
    int         ef;
    bit         emq;
    int         ec;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit xb, input bit l,
                      input logic [3:0] p, input bit te = 1'b0, input bit em = 1'b0,
                      input int ef = 0, input bit emq = 1'b0, input int ec = 0);
    bit ea, eb;
    int sa, sb;
    ea = 1'b0;
    eb = 1'b0;
    @(negedge clk);
    reset = r; in_valid = v; x = xb; pat_load = l; pat_in = p;
    #1;
    sa = qa.size();
    sb = qb.size();
    if (!r && !l && v && sa == 3) ea = ({qa[0], qa[1], qa[2], xb} == pat_m);
    if (!r && !l && v && sb == 3) eb = ({qb[0], qb[1], qb[2], xb} == pat_m);
    if (chk_en) begin
      check("a.match", 32'(m_a), 32'(ea));
      check("a.fill", 32'(fill_a), 32'(sa));
      check("a.match_q", 32'(mq_a_o), 32'(mq_a));
      check("a.match_cnt", 32'(cnt_a_o), 32'(cnt_a));
      check("b.match", 32'(m_b), 32'(eb));
      check("b.fill", 32'(fill_b), 32'(sb));
      check("b.match_q", 32'(mq_b_o), 32'(mq_b));
      check("b.match_cnt", 32'(cnt_b_o), 32'(cnt_b));
      check("c.match", 32'(m_c), 32'(ea));
      check("c.fill", 32'(fill_c), 32'(sa));
      check("c.match_q", 32'(mq_c_o), 32'(mq_c));
      check("c.match_cnt", 32'(cnt_c_o), 32'(cnt_c));
    end
    if (te) begin
      check("tbl.match", 32'(m_a), 32'(em));
      check("tbl.fill", 32'(fill_a), 32'(ef));
      check("tbl.match_q", 32'(mq_a_o), 32'(emq));
      check("tbl.match_cnt", 32'(cnt_a_o), 32'(ec));
    end
    @(posedge clk);
    if (r) begin
      pat_m = 4'b1011;
      qa.delete(); qb.delete();
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      mq_a = 1'b0; mq_b = 1'b0; mq_c = 1'b0;
    end else if (l) begin
      pat_m = p;
      qa.delete(); qb.delete();
      mq_a = 1'b0; mq_b = 1'b0; mq_c = 1'b0;
    end else if (v) begin
      qa.push_back(xb);
      if (qa.size() > 3) void'(qa.pop_front());
      if (eb) qb.delete();
      else begin
        qb.push_back(xb);
        if (qb.size() > 3) void'(qb.pop_front());
      end
      mq_a = ea; mq_b = eb; mq_c = ea;
      if (ea && cnt_a < 255) cnt_a++;
      if (eb && cnt_b < 255) cnt_b++;
      if (ea && cnt_c < 3) cnt_c++;
    end else begin
      mq_a = 1'b0; mq_b = 1'b0; mq_c = 1'b0;
    end
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b0, 4'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 0, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 0, 1'b0, 0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1, 1'b0, 0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2, 1'b0, 0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 3, 1'b0, 0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3, 1'b1, 1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 3, 1'b0, 1};

    do_reset();
    chk_en = 1'b1;

    // Basic detection
    for (int i = 0; i < 7; i++)
      step(tbl[i].r, tbl[i].v, tbl[i].xb, tbl[i].l, tbl[i].p,
           1'b1, tbl[i].em, tbl[i].ef, tbl[i].emq, tbl[i].ec);

    // Overlap vs non-overlap
    do_reset();
    send(32'b1011011, 7);
    #2;
    check("ovl.cnt_a", 32'(cnt_a_o), 32'd2);
    check("ovl.cnt_b", 32'(cnt_b_o), 32'd1);

    // Valid gaps with x toggling
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    #2;
    check("gap.cnt_a", 32'(cnt_a_o), 32'd1);

    // Runtime load; the load-cycle bit is ignored
    do_reset();
    send(32'b101, 3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110);
    #2;
    check("load.fill", 32'(fill_a), 32'd0);
    send(32'b0110, 4);
    #2;
    check("load.cnt_new", 32'(cnt_a_o), 32'd1);
    send(32'b1011, 4);
    #2;
    check("load.cnt_old", 32'(cnt_a_o), 32'd1);

    // Counter saturation with all-ones pattern
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111);
    send(32'h3FF, 10);
    #2;
    check("sat.cnt_c", 32'(cnt_c_o), 32'd3);
    check("sat.cnt_a", 32'(cnt_a_o), 32'd7);

    // Reset while armed with the completing bit present
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
    send(32'b0110011, 7);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    #2;
    check("rst.fill", 32'(fill_a), 32'd0);
    check("rst.cnt_a", 32'(cnt_a_o), 32'd0);
    check("rst.mq_a", 32'(mq_a_o), 32'd0);
    send(32'b1011, 4);
    #2;
    check("rst.pat_init", 32'(cnt_a_o), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 31) == 0, rp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mealy_seq_detector.md
# mealy_seq_detector

- Parametrised serial sequence detector: the next generation of the team's two-output Mealy FSM.
- Watches a qualified 1-bit input stream for a runtime-programmable PAT_W-bit pattern.
- Outputs:
  - a same-cycle Mealy match pulse;
  - a one-cycle-delayed registered (Moore-style) copy;
  - a saturating match counter.
- Sits between a bit-serial source and control logic that needs either zero-latency or glitch-free registered detection.

## Interface
- PAT_W, 4: pattern length in bits, ≥2.
- PAT_INIT, 4'b1011: pattern after reset, PAT_W bits. Bit PAT_W-1 is the oldest (first-received) bit.
- OVERLAP, 1: 1 allows overlapping matches; 0 clears history after every match.
- CNT_W, 8: match counter width.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies x; when low, the stream does not advance.
- x  input  1  serial data bit.
- pat_load  input  1  load pat_in as the new pattern.
- pat_in  input  PAT_W  pattern to load.
- match  output  1  Mealy output, combinational from state and current inputs.
- match_q  output  1  registered copy of match.
- match_cnt  output  CNT_W  number of matches, saturating.
- fill  output  $clog2(PAT_W)  number of valid history bits, 0..PAT_W-1.

## Operation
State registers:
- pat[PAT_W-1:0]
- hist[PAT_W-2:0]: most recent bit at bit 0
- fill
- match_q
- match_cnt

Reset (clk edge with reset=1):
- pat = PAT_INIT, hist = 0, fill = 0, match_q = 0, match_cnt = 0.
- match is 0 while reset is high.

Match equation:
- match = in_valid & ~pat_load & ~reset & (fill == PAT_W-1) & ({hist, x} == pat).

Per clock edge, priority order:
1. reset: applies the reset values above.
2. pat_load=1:
   - pat ← pat_in; hist ← 0; fill ← 0; match_q ← 0.
   - in_valid/x are ignored this cycle.
   - match_cnt is held.
3. in_valid=1:
   - History update:
     - If match and OVERLAP=0: hist ← 0, fill ← 0.
     - Otherwise: hist ← {hist[PAT_W-3:0], x}, and fill ← min(fill+1, PAT_W-1).
   - match_q ← match.
   - If match and match_cnt ≠ all-ones: match_cnt ← match_cnt + 1.
4. in_valid=0:
   - hist, fill, pat and match_cnt are held.
   - match_q ← 0.

Fill states:
- 0..PAT_W-2: filling; match is impossible.
- PAT_W-1: armed; a match is evaluated on every valid bit.

Boundary rules:
- match_cnt saturates at 2^CNT_W-1 and never wraps.
- A mid-stream pattern load discards partial history, so the next match needs PAT_W fresh valid bits.
- Reset mid-stream behaves the same as reset at power-up.

## Timing
- match: 0-cycle latency. It is valid in the same cycle as the completing x/in_valid, so it must be sampled by the consumer before the edge.
- match_q: high for exactly the one cycle following the edge at which match was high.
- match_cnt: increments at the same edge that registers match_q.
- Pattern load: takes effect at the loading edge. The earliest possible match is the PAT_W-th valid bit after the load cycle.
- Throughput: one bit per cycle. Back-to-back matches are possible every cycle only for OVERLAP=1 with suitable patterns (e.g. all-ones).

## Test plan
All scenarios use PAT_W=4.

- Basic detection:
  - Stimulus: reset, then valid x = 1,0,1,1.
  - Required: match=1 combinationally on the 4th bit, match_q=1 the next cycle, match_cnt=1, fill sequence 0,1,2,3.
- Overlap vs non-overlap:
  - Stimulus: x = 1,0,1,1,0,1,1.
  - OVERLAP=1: 2 matches (bits 4 and 7), match_cnt=2.
  - OVERLAP=0: 1 match (bit 4 only), match_cnt=1.
- Valid gaps:
  - Stimulus: 1,0,1,1 with in_valid=0 cycles inserted between bits (x toggling during the gaps).
  - Required: exactly 1 match; match stays 0 during the gaps; fill is held during the gaps.
- Runtime load:
  - Stimulus: load pat_in=4'b0110 after bits 1,0,1 have been sent; in the same cycle drive in_valid=1, x=1.
  - Required: the load-cycle bit is ignored and fill=0. Then 0,1,1,0 gives a match; 1,0,1,1 gives none.
- Counter saturation:
  - Stimulus: CNT_W=2, OVERLAP=1, pattern 4'b1111, continuous x=1 for 10 valid bits.
  - Required: match=1 on bits 4..10; match_cnt = 1,2,3, then held at 3.
- Reset mid-operation:
  - Stimulus: assert reset while fill=3 and the armed pattern bit is present on x.
  - Required: match=0; after the edge, match_q=0, match_cnt=0, fill=0, and pat returns to PAT_INIT.
